// File: rtl/hazard_ctrl_if.sv
// Bundle of the hazard controller's pipeline-facing signals.
// The master side is the datapath/decoder; the slave side is the controller.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             ifid_uses_rt_i;
    logic             branch_taken_i;
    logic             mem_busy_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
    logic             exmem_flush_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] freeze_cnt_o;

    modport master (
        output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
               branch_taken_i, mem_busy_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o,
               state_o, stall_cnt_o, flush_cnt_o, freeze_cnt_o
    );

    modport slave (
        input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
               branch_taken_i, mem_busy_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o,
               state_o, stall_cnt_o, flush_cnt_o, freeze_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS CPU: load-use stalls,
// taken-branch flushes, data-memory freezes with a pending-branch state, and
// saturating performance counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_FREEZE = 2'b01,
        ST_PEND   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ACT_PASS,
        ACT_STALL,
        ACT_FLUSH,
        ACT_HOLD
    } act_t;

    state_t           state_q;
    state_t           state_nxt;
    act_t             act;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] freeze_cnt_q;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Action when memory is ready: a branch outranks a load-use hazard.
    function automatic act_t ready_action(input logic br, input logic lu);
        if (br)      return ACT_FLUSH;
        else if (lu) return ACT_STALL;
        else         return ACT_PASS;
    endfunction

    // Register zero never creates a dependency.
    always_comb begin
        load_use = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                   ((bus.idex_rt_i == bus.ifid_rs_i) ||
                    (bus.ifid_uses_rt_i && (bus.idex_rt_i == bus.ifid_rt_i)));
    end

    // Next-state and action selection.
    always_comb begin
        state_nxt = state_q;
        act       = ACT_PASS;
        case (state_q)
            ST_RUN, ST_FREEZE: begin
                if (bus.mem_busy_i) begin
                    act = ACT_HOLD;
                    if (bus.branch_taken_i) state_nxt = ST_PEND;
                    else                    state_nxt = ST_FREEZE;
                end else begin
                    act       = ready_action(bus.branch_taken_i, load_use);
                    state_nxt = ST_RUN;
                end
            end
            ST_PEND: begin
                // The captured branch is replayed; new pulses and hazards are ignored.
                if (bus.mem_busy_i) begin
                    act = ACT_HOLD;
                end else begin
                    act       = ACT_FLUSH;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                act       = ACT_PASS;
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Decode the action into enables/flushes; everything is held off during reset.
    always_comb begin
        bus.pc_write_o    = 1'b0;
        bus.ifid_write_o  = 1'b0;
        bus.ifid_flush_o  = 1'b0;
        bus.idex_flush_o  = 1'b0;
        bus.exmem_flush_o = 1'b0;
        if (!rst_i) begin
            case (act)
                ACT_PASS: begin
                    bus.pc_write_o   = 1'b1;
                    bus.ifid_write_o = 1'b1;
                end
                ACT_STALL: begin
                    bus.idex_flush_o = 1'b1;
                end
                ACT_FLUSH: begin
                    bus.pc_write_o    = 1'b1;
                    bus.ifid_write_o  = 1'b1;
                    bus.ifid_flush_o  = 1'b1;
                    bus.idex_flush_o  = 1'b1;
                    bus.exmem_flush_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State register; reset drops any pending branch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_RUN;
        else       state_q <= state_nxt;
    end

    // Performance counters, one per action class.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (act == ACT_STALL) stall_cnt_q  <= sat_inc(stall_cnt_q);
            if (act == ACT_FLUSH) flush_cnt_q  <= sat_inc(flush_cnt_q);
            if (act == ACT_HOLD)  freeze_cnt_q <= sat_inc(freeze_cnt_q);
        end
    end

    assign bus.state_o      = state_q;
    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.flush_cnt_o  = flush_cnt_q;
    assign bus.freeze_cnt_o = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: main instance at CNT_W=16 plus a
// CNT_W=2 instance for counter saturation.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    localparam logic [4:0] O_PASS  = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_FLUSH = 5'b11111;
    localparam logic [4:0] O_HOLD  = 5'b00000;

    hazard_ctrl_if #(.CNT_W(16)) bus ();
    hazard_ctrl_if #(.CNT_W(2))  sbus ();

    hazard_ctrl #(.CNT_W(16)) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    hazard_ctrl #(.CNT_W(2))  u_sat (.clk_i(clk), .rst_i(rst), .bus(sbus));

    always #5 clk = ~clk;

    wire [4:0] outs  = {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
                        bus.idex_flush_o, bus.exmem_flush_o};
    wire [4:0] souts = {sbus.pc_write_o, sbus.ifid_write_o, sbus.ifid_flush_o,
                        sbus.idex_flush_o, sbus.exmem_flush_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 2 time units after it.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic br,
                         input logic busy);
        bus.idex_memread_i = mr;
        bus.idex_rt_i      = irt;
        bus.ifid_rs_i      = rs;
        bus.ifid_rt_i      = rt;
        bus.ifid_uses_rt_i = urt;
        bus.branch_taken_i = br;
        bus.mem_busy_i     = busy;
        #1;
    endtask

    initial begin
        sbus.idex_memread_i = 1'b0;
        sbus.idex_rt_i      = 5'd0;
        sbus.ifid_rs_i      = 5'd0;
        sbus.ifid_rt_i      = 5'd0;
        sbus.ifid_uses_rt_i = 1'b0;
        sbus.branch_taken_i = 1'b0;
        sbus.mem_busy_i     = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset state
        chk("rst_outs", 32'(outs), 32'(O_HOLD));
        chk("rst_state", 32'(bus.state_o), 0);
        chk("rst_stall", 32'(bus.stall_cnt_o), 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("idle_pass", 32'(outs), 32'(O_PASS));

        // Load-use on rs: single-cycle stall
        drive(1, 2, 2, 4, 1, 0, 0);
        chk("lu_rs_outs", 32'(outs), 32'(O_STALL));
        cyc();
        drive(0, 2, 2, 4, 1, 0, 0);
        chk("lu_rs_cnt", 32'(bus.stall_cnt_o), 1);
        chk("lu_rs_after", 32'(outs), 32'(O_PASS));

        // rt match only counts when the instruction reads rt
        drive(1, 5, 1, 5, 0, 0, 0);
        chk("lu_rt_unused", 32'(outs), 32'(O_PASS));
        drive(1, 5, 1, 5, 1, 0, 0);
        chk("lu_rt_used", 32'(outs), 32'(O_STALL));
        cyc();
        chk("lu_rt_cnt", 32'(bus.stall_cnt_o), 2);

        // Register zero never stalls
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("r0_outs", 32'(outs), 32'(O_PASS));
        cyc();
        chk("r0_cnt", 32'(bus.stall_cnt_o), 2);

        // Branch beats load-use
        drive(1, 2, 2, 0, 0, 1, 0);
        chk("br_outs", 32'(outs), 32'(O_FLUSH));
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("br_flushcnt", 32'(bus.flush_cnt_o), 1);
        chk("br_stallcnt", 32'(bus.stall_cnt_o), 2);
        chk("br_state", 32'(bus.state_o), 0);

        // Freeze x4 with branch in cycle 2, then pending flush
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("fz1_outs", 32'(outs), 32'(O_HOLD));
        cyc();
        chk("fz1_state", 32'(bus.state_o), 1);
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("fz2_outs", 32'(outs), 32'(O_HOLD));
        cyc();
        chk("fz2_state", 32'(bus.state_o), 2);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("fz3_outs", 32'(outs), 32'(O_HOLD));
        cyc();
        chk("fz3_state", 32'(bus.state_o), 2);
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("fz4_outs", 32'(outs), 32'(O_HOLD));
        cyc();
        chk("fz4_state", 32'(bus.state_o), 2);
        drive(1, 3, 3, 0, 0, 1, 0);
        chk("pend_flush", 32'(outs), 32'(O_FLUSH));
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("pend_state", 32'(bus.state_o), 0);
        chk("pend_frzcnt", 32'(bus.freeze_cnt_o), 4);
        chk("pend_flushcnt", 32'(bus.flush_cnt_o), 2);
        chk("pend_stallcnt", 32'(bus.stall_cnt_o), 2);

        // Leaving FREEZE applies the run rules in the same cycle
        drive(0, 0, 0, 0, 0, 0, 1);
        cyc();
        chk("fzlu_state1", 32'(bus.state_o), 1);
        drive(1, 7, 7, 0, 0, 0, 0);
        chk("fzlu_outs", 32'(outs), 32'(O_STALL));
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("fzlu_state", 32'(bus.state_o), 0);
        chk("fzlu_stall", 32'(bus.stall_cnt_o), 3);
        chk("fzlu_frz", 32'(bus.freeze_cnt_o), 5);

        // Saturation with a 2-bit counter
        sbus.idex_memread_i = 1'b1;
        sbus.idex_rt_i      = 5'd9;
        sbus.ifid_rs_i      = 5'd9;
        #1;
        chk("sat_outs", 32'(souts), 32'(O_STALL));
        for (int i = 0; i < 3; i++) cyc();
        chk("sat_cnt3", 32'(sbus.stall_cnt_o), 3);
        for (int i = 0; i < 2; i++) cyc();
        chk("sat_cnt5", 32'(sbus.stall_cnt_o), 3);
        sbus.idex_memread_i = 1'b0;

        // Async reset while pending discards the branch
        drive(0, 0, 0, 0, 0, 0, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 1, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("pre_rst_state", 32'(bus.state_o), 2);
        rst = 1'b1;
        #1;
        chk("arst_outs", 32'(outs), 32'(O_HOLD));
        chk("arst_state", 32'(bus.state_o), 0);
        chk("arst_frz", 32'(bus.freeze_cnt_o), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_outs", 32'(outs), 32'(O_PASS));
        cyc();
        chk("post_rst_state", 32'(bus.state_o), 0);
        chk("post_rst_flush", 32'(bus.flush_cnt_o), 0);
        chk("post_rst_stall", 32'(bus.stall_cnt_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
